// File: rtl/timer_contagem.sv
// BCD minutes:seconds countdown timer with digit entry (ENTRY mode) and 1 Hz countdown (COUNT mode).
// Build option: define TIMER_DONE_PULSE_EN to get a registered one-cycle done pulse; otherwise done is tied 0.
module timer_contagem (
    input  logic       clk100,
    input  logic       clear,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       enablen,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic       zero,
    output logic       done
);

    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic       loadn_q, loadn_d;
    logic       tick_q, tick_d;

    logic load_ev;
    logic tick_ev;
    logic count_mode;
    logic count_step;

    assign load_ev    = !loadn && loadn_q;
    assign tick_ev    = pgt_1Hz && !tick_q;
    assign count_mode = !enablen;
    assign zero       = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) && (min_ones_q == 4'd0);
    assign count_step = count_mode && tick_ev && !zero;

    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        loadn_d    = loadn;
        tick_d     = pgt_1Hz;
        if (!count_mode && load_ev && (D <= 4'd9)) begin
            min_ones_d = sec_tens_q;
            sec_tens_d = sec_ones_q;
            sec_ones_d = D;
        end else if (count_step) begin
            // Tens borrow to 5 regardless of entered value, so 1:75 runs down through 1:00 to 0:59.
            if (sec_ones_q != 4'd0) begin
                sec_ones_d = sec_ones_q - 4'd1;
            end else begin
                sec_ones_d = 4'd9;
                if (sec_tens_q != 4'd0) begin
                    sec_tens_d = sec_tens_q - 4'd1;
                end else begin
                    sec_tens_d = 4'd5;
                    min_ones_d = min_ones_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk100) begin
        if (clear) begin
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            loadn_q    <= 1'b1;
            tick_q     <= 1'b1;
        end else begin
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            loadn_q    <= loadn_d;
            tick_q     <= tick_d;
        end
    end

    assign sec_ones = sec_ones_q;
    assign sec_tens = sec_tens_q;
    assign min_ones = min_ones_q;

`ifdef TIMER_DONE_PULSE_EN
    logic done_q, done_d;

    // Only the final 0:01 -> 0:00 step qualifies; clear and idle ticks at 0:00 never do.
    always_comb begin
        done_d = count_step && (min_ones_q == 4'd0) && (sec_tens_q == 4'd0) && (sec_ones_q == 4'd1);
    end

    always_ff @(posedge clk100) begin
        if (clear) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done = done_q;
`else
    assign done = 1'b0;
`endif

endmodule
